// File: rtl/mux_pkg.sv
// mux_pkg: arbitration mode constants and wrapping first-set search shared by the stream mux.
package mux_pkg;
  localparam int MODE_RR   = 0;
  localparam int MODE_PRIO = 1;
  localparam int MAXCH     = 16;
  function automatic logic [3:0] first_set(input logic [MAXCH-1:0] req, input logic [3:0] start, input int n);
    logic [3:0] r;
    logic found;
    int c;
    r = '0;
    found = 1'b0;
    for (int i = 0; i < MAXCH; i++) begin
      c = (int'(start) + i) % n;
      if (i < n && !found && req[c]) begin
        r = 4'(c);
        found = 1'b1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/mux_stream_rr_grant.sv
// rr_grant: one-hot grant and binary index over req, searching upward from ptr (or from 0 in priority mode).
module rr_grant
  import mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int MODE     = MODE_RR,
  parameter int IDXW     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IDXW-1:0]     ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [IDXW-1:0]     idx
);
  always_comb begin
    idx   = IDXW'(first_set(MAXCH'(req), MODE == MODE_PRIO ? 4'd0 : 4'(ptr), CHANNELS));
    grant = |req ? CHANNELS'(1) << idx : '0;
  end
endmodule

// File: rtl/mux_stream_rr.sv
// mux_stream_rr: N:1 valid/ready stream mux with registered output, round-robin or fixed-priority arbitration.
module mux_stream_rr
  import mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MODE     = MODE_RR,
  parameter int IDXW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       d_valid,
  output logic [CHANNELS-1:0]       d_ready,
  output logic [WIDTH-1:0]          out,
  output logic [IDXW-1:0]           out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);
  logic [WIDTH-1:0]    out_q, out_d;
  logic [IDXW-1:0]     sel_q, sel_d, ptr_q, ptr_d, idx;
  logic                valid_q, valid_d, load;
  logic [CHANNELS-1:0] grant;
  rr_grant #(.CHANNELS(CHANNELS), .MODE(MODE), .IDXW(IDXW)) u_grant (
    .req(d_valid), .ptr(ptr_q), .grant(grant), .idx(idx)
  );
  assign load      = !valid_q | out_ready;
  assign d_ready   = grant & {CHANNELS{load & !rst}};
  assign out       = out_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;
  // Priority mode never moves the pointer; it stays at its reset value.
  always_comb begin
    out_d   = out_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = |d_valid;
      if (|d_valid) begin
        out_d = d[idx*WIDTH +: WIDTH];
        sel_d = idx;
        ptr_d = MODE == MODE_RR ? (idx == IDXW'(CHANNELS-1) ? '0 : idx + 1'b1) : '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      out_q   <= out_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end
endmodule

// File: tb/tb_mux_stream_rr.sv
// tb_mux_stream_rr: scoreboard bench running a round-robin and a fixed-priority instance on shared stimulus.
module tb_mux_stream_rr;
  typedef struct {
    logic [7:0] data;
    int         sel;
  } word_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d = '0;
  logic [3:0]  d_valid = '0;
  logic        out_ready = 1'b0;
  logic [3:0]  rdy_r, rdy_p;
  logic [7:0]  out_r, out_p;
  logic [1:0]  sel_r, sel_p;
  logic        val_r, val_p;
  int          compared = 0;
  int          mismatched = 0;
  word_t       sbq[2][$];
  int          mptr[2];
  bit          mval[2];
  always #5 clk = ~clk;
  mux_stream_rr #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u_rr (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(rdy_r),
    .out(out_r), .out_sel(sel_r), .out_valid(val_r), .out_ready(out_ready)
  );
  mux_stream_rr #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u_pr (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(rdy_p),
    .out(out_p), .out_sel(sel_p), .out_valid(val_p), .out_ready(out_ready)
  );
  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, m, $time, act, exp);
    end
  endtask
  // Reference arbitration: round-robin scans from the pointer with wrap, priority scans from 0.
  function automatic int pick(input int mode, input logic [3:0] v, input int p);
    for (int i = 0; i < 4; i++) begin
      int c;
      c = mode == 1 ? i : (p + i) % 4;
      if (v[c]) return c;
    end
    return -1;
  endfunction
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        sbq[m].delete();
        mptr[m] = 0;
        mval[m] = 0;
      end else if (!mval[m] || out_ready) begin
        int c;
        c = pick(m, d_valid, mptr[m]);
        if (c >= 0) begin
          word_t w;
          w.data = d[c*8 +: 8];
          w.sel  = c;
          sbq[m].push_back(w);
          mval[m] = 1;
          if (m == 0) mptr[m] = (c + 1) % 4;
        end else mval[m] = 0;
      end
    end
  end
  task automatic mon(input int m, input logic [7:0] o, input logic [1:0] s, input logic v, input logic [3:0] r);
    int c;
    logic [3:0] er;
    c = pick(m, d_valid, mptr[m]);
    er = (!rst && (!mval[m] || out_ready) && c >= 0) ? 4'(1 << c) : 4'd0;
    chk("d_ready", m, 32'(r), 32'(er));
    chk("out_valid", m, 32'(v), 32'(mval[m]));
    if (v === 1'b1) begin
      if (sbq[m].size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL scoreboard dut%0d t=%0t: out_valid with no expected word (out=%0h)", m, $time, o);
      end else begin
        chk("out", m, 32'(o), 32'(sbq[m][0].data));
        chk("out_sel", m, 32'(s), 32'(sbq[m][0].sel));
        if (out_ready) void'(sbq[m].pop_front());
      end
    end
  endtask
  always @(negedge clk) begin
    mon(0, out_r, sel_r, val_r, rdy_r);
    mon(1, out_p, sel_p, val_p, rdy_p);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    d_valid = 4'b1111;
    d = 32'h44332211;
    out_ready = 1'b1;
    repeat (2) step();
    @(negedge clk);
    #1;
    chk("rst_out", 0, 32'(out_r), 0);
    chk("rst_sel", 0, 32'(sel_r), 0);
    chk("rst_out", 1, 32'(out_p), 0);
    chk("rst_sel", 1, 32'(sel_p), 0);
    step();
    rst = 1'b0;
    repeat (6) step();
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    repeat (3) step();
    d_valid = 4'b0101;
    repeat (4) step();
    d_valid = 4'b1110;
    repeat (5) step();
    d_valid = 4'b1111;
    out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 3000; i++) begin
      d = $urandom;
      d_valid = 4'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 99) == 0;
      step();
    end
    rst = 1'b0;
    d_valid = '0;
    out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
